display_scan_mux: RTL

Time-multiplexing front end for the four-digit HH:MM seven-segment display. It scans the four BCD digits of the clock or alarm time in turn and drives the digit decoder's 2-bit digit select (`scan_sel`) and 4-bit BCD value (`digit_out`). It also applies digit blanking: leading-zero suppression, setting-mode blink and invalid-code blanking. Digit values are captured once per frame so a digit never changes part-way through a scan.

---
 rtl/display_scan_mux_if.sv | 28 ++
 rtl/display_scan_mux.sv | 106 ++++++++++
 2 files changed

// File: rtl/display_scan_mux_if.sv
// Signal bundle between the time-base/digit sources and the display scan front end.
// The source drives the BCD digits and display controls; the scanner returns the decoder drive.
interface display_scan_mux_if;
    logic [3:0] hours_tens;
    logic [3:0] hours_units;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] blink_mask;
    logic       lz_blank;
    logic       colon_in;
    logic [1:0] scan_sel;
    logic [3:0] digit_out;
    logic       blank;
    logic       dp;
    logic       frame_tick;

    modport master (
        output hours_tens, hours_units, min_tens, min_units,
        output blink_mask, lz_blank, colon_in,
        input  scan_sel, digit_out, blank, dp, frame_tick
    );

    modport slave (
        input  hours_tens, hours_units, min_tens, min_units,
        input  blink_mask, lz_blank, colon_in,
        output scan_sel, digit_out, blank, dp, frame_tick
    );
endinterface

// File: rtl/display_scan_mux.sv
// Four-digit HH:MM scan multiplexer with per-frame digit snapshot,
// leading-zero suppression, blink blanking and invalid-code blanking.
module display_scan_mux #(
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned BLINK_DIV = 50_000_000
) (
    input logic               clk,
    input logic               reset,
    display_scan_mux_if.slave bus
);
    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_n;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_n;
    logic [1:0]         sel_q,       sel_n;
    logic               phase_q,     phase_n;
    logic               loaded_q;
    logic [3:0][3:0]    snap_dig_q,  snap_dig_n;
    logic [3:0]         snap_mask_q, snap_mask_n;
    logic               snap_lz_q,   snap_lz_n;
    logic               snap_col_q,  snap_col_n;

    logic       scan_wrap, blink_wrap, load;
    logic [3:0] digit_n;
    logic       blank_n, dp_n, tick_n;

    // Next-state and next-output computation; outputs derive from next state so they never lag scan_sel.
    always_comb begin
        scan_cnt_n  = scan_cnt_q;
        blink_cnt_n = blink_cnt_q;
        sel_n       = sel_q;
        phase_n     = phase_q;
        snap_dig_n  = snap_dig_q;
        snap_mask_n = snap_mask_q;
        snap_lz_n   = snap_lz_q;
        snap_col_n  = snap_col_q;

        scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        load       = !loaded_q || (scan_wrap && (sel_q == 2'd3));

        if (scan_wrap) begin
            scan_cnt_n = '0;
            sel_n      = sel_q + 2'd1;
        end else begin
            scan_cnt_n = scan_cnt_q + SCAN_W'(1);
        end

        if (blink_wrap) begin
            blink_cnt_n = '0;
            phase_n     = !phase_q;
        end else begin
            blink_cnt_n = blink_cnt_q + BLINK_W'(1);
        end

        if (load) begin
            snap_dig_n  = {bus.min_units, bus.min_tens, bus.hours_units, bus.hours_tens};
            snap_mask_n = bus.blink_mask;
            snap_lz_n   = bus.lz_blank;
            snap_col_n  = bus.colon_in;
        end

        digit_n = snap_dig_n[sel_n];
        blank_n = (snap_mask_n[sel_n] && !phase_n)
               || ((sel_n == 2'd0) && snap_lz_n && (snap_dig_n[0] == 4'd0))
               || (digit_n > 4'd9);
        dp_n    = (sel_n == 2'd1) && snap_col_n && phase_n;
        tick_n  = scan_wrap && (sel_q == 2'd3);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q     <= '0;
            blink_cnt_q    <= '0;
            sel_q          <= 2'd0;
            phase_q        <= 1'b1;
            loaded_q       <= 1'b0;
            snap_dig_q     <= '0;
            snap_mask_q    <= 4'd0;
            snap_lz_q      <= 1'b0;
            snap_col_q     <= 1'b0;
            bus.scan_sel   <= 2'd0;
            bus.digit_out  <= 4'd0;
            bus.blank      <= 1'b1;
            bus.dp         <= 1'b0;
            bus.frame_tick <= 1'b0;
        end else begin
            scan_cnt_q     <= scan_cnt_n;
            blink_cnt_q    <= blink_cnt_n;
            sel_q          <= sel_n;
            phase_q        <= phase_n;
            loaded_q       <= 1'b1;
            snap_dig_q     <= snap_dig_n;
            snap_mask_q    <= snap_mask_n;
            snap_lz_q      <= snap_lz_n;
            snap_col_q     <= snap_col_n;
            bus.scan_sel   <= sel_n;
            bus.digit_out  <= digit_n;
            bus.blank      <= blank_n;
            bus.dp         <= dp_n;
            bus.frame_tick <= tick_n;
        end
    end
endmodule
